// File: rtl/swo_uart_rx.sv
// ============================================================================
//  Module   : swo_uart_rx
//  Purpose  : SWO NRZ/UART receiver. Decodes 8N1 frames from the SWO pin and
//             presents bytes through a single-entry valid/ready holding
//             register, with sticky framing and overrun flags.
//  Option   : define SWO_GLITCH_FILTER_EN to add a 3-sample majority filter
//             on the synchronized line (+1 cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swo_uart_rx #(
    parameter int pDIV_WIDTH = 12
) (
    input  logic                  trace_clk,
    input  logic                  reset_n,
    input  logic                  I_swo,
    input  logic                  I_enable,
    input  logic [pDIV_WIDTH-1:0] I_baud_div,
    input  logic                  I_clear_errors,
    output logic [7:0]            O_data,
    output logic                  O_data_valid,
    input  logic                  I_data_ready,
    output logic                  O_framing_error,
    output logic                  O_overrun,
    output logic                  O_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    localparam logic [pDIV_WIDTH-1:0] c_MIN_DIV = pDIV_WIDTH'(3);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_swo_prev;
    logic                    w_swo_s;
    logic                    w_fall;
    logic [pDIV_WIDTH-1:0]   w_eff_div;
    logic [pDIV_WIDTH-1:0]   w_half_m1;
    logic [pDIV_WIDTH-1:0]   r_div;
    logic [pDIV_WIDTH-1:0]   w_div_nxt;
    logic [pDIV_WIDTH-1:0]   r_cnt;
    logic [pDIV_WIDTH-1:0]   w_cnt_nxt;
    logic                    w_cnt_zero;
    logic [7:0]              r_shift;
    logic [7:0]              w_shift_nxt;
    logic [2:0]              r_bitcnt;
    logic [2:0]              w_bitcnt_nxt;
    logic                    w_deliver;
    logic                    w_frame_err;
    logic [7:0]              r_data;
    logic                    r_valid;
    logic                    r_fe;
    logic                    r_ov;
    logic                    w_ov_set;

    // Two-flop synchronizer for the asynchronous SWO pin, idling high
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= I_swo;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SWO_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    // History of the two previous synchronized samples for the majority vote
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    assign w_swo_s = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
    assign w_swo_s = r_sync2;
`endif

    // Previous line level, used for 1->0 start-edge detection
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_swo_prev <= 1'b1;
        end else begin
            r_swo_prev <= w_swo_s;
        end
    end

    assign w_fall = r_swo_prev & ~w_swo_s;

    // Divisors below 3 leave no room for a mid-bit sample, so clamp to 3.
    // The counter holds "cycles left minus one", hence the reloads are
    // half-1 for the start bit and eff_div for each full bit period.
    // half-1 = ((eff_div+1)>>1) - 1 = (eff_div>>1) - (eff_div even ? 1 : 0).
    assign w_eff_div  = (I_baud_div < c_MIN_DIV) ? c_MIN_DIV : I_baud_div;
    assign w_half_m1  = (w_eff_div >> 1) - pDIV_WIDTH'(!w_eff_div[0]);
    assign w_cnt_zero = (r_cnt == '0);

    // FSM state and frame datapath registers
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    // Next-state and frame control; enable low overrides everything to IDLE
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_cnt_nxt    = w_cnt_zero ? r_cnt : (r_cnt - pDIV_WIDTH'(1));
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_deliver    = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = w_half_m1;
                    w_div_nxt   = w_eff_div;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    if (!w_swo_s) begin
                        w_state_nxt  = S_DATA;
                        w_cnt_nxt    = r_div;
                        w_bitcnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt  = {w_swo_s, r_shift[7:1]};
                    w_cnt_nxt    = r_div;
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (w_swo_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_swo_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!I_enable) begin
            w_state_nxt = S_IDLE;
            w_deliver   = 1'b0;
            w_frame_err = 1'b0;
        end
    end

    assign w_ov_set = w_deliver & r_valid & ~I_data_ready;

    // Single-entry holding register with valid/ready handshake
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_deliver && (!r_valid || I_data_ready)) begin
            r_data  <= w_shift_nxt;
            r_valid <= 1'b1;
        end else if (r_valid && I_data_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fe <= 1'b0;
            r_ov <= 1'b0;
        end else begin
            if (w_frame_err) begin
                r_fe <= 1'b1;
            end else if (I_clear_errors) begin
                r_fe <= 1'b0;
            end
            if (w_ov_set) begin
                r_ov <= 1'b1;
            end else if (I_clear_errors) begin
                r_ov <= 1'b0;
            end
        end
    end

    assign O_data          = r_data;
    assign O_data_valid    = r_valid;
    assign O_framing_error = r_fe;
    assign O_overrun       = r_ov;
    assign O_busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/swo_uart_rx.md
# swo_uart_rx

Receives the target's Serial Wire Output (SWO) in NRZ/UART mode and turns it into bytes for the trace capture path. It sits directly upstream of trace capture, after board-revision pin selection has produced the `swo` line. It presents each decoded byte through a single-entry valid/ready holding register. Framing and overrun errors are reported as sticky flags.

## Interface
Parameters:
- `pDIV_WIDTH`, 12: width of the bit-period divisor.

Ports (one clock; reset is asynchronous and active-low):
- `trace_clk`  input  1  sampling clock; all logic is on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `I_swo`  input  1  raw SWO line; asynchronous to `trace_clk`; idle level is high.
- `I_enable`  input  1  receiver enable.
- `I_baud_div`  input  pDIV_WIDTH  bit period in `trace_clk` cycles, minus 1.
- `I_clear_errors`  input  1  one-cycle pulse that clears the sticky error flags.
- `O_data`  output  8  received byte.
- `O_data_valid`  output  1  `O_data` holds an unconsumed byte.
- `I_data_ready`  input  1  consumer accepts the byte this cycle.
- `O_framing_error`  output  1  sticky: a stop bit was sampled low.
- `O_overrun`  output  1  sticky: a byte was dropped because the holding register was full.
- `O_busy`  output  1  FSM is not in IDLE.

## Operation
- **Input path:** `I_swo` passes through a 2-flop synchronizer, reset value 1. The result is `swo_s`.
- **Divisor:** `eff_div = max(I_baud_div, 3)`. `half = (eff_div + 1) >> 1`. The divisor is latched at the start-bit edge and is stable for the whole frame.
- **FSM states:**
  - IDLE: when `swo_s` goes 1→0, load the counter with `half` and go to START.
  - START: when the counter expires, sample the line. Low → load `eff_div`, go to DATA. High → false start, return to IDLE.
  - DATA: sample 8 bits, LSB first, each `eff_div + 1` cycles apart. After bit 7, go to STOP.
  - STOP: sample once.
    - High → deliver the byte, return to IDLE.
    - Low → set `O_framing_error`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until `swo_s` is high, then go to IDLE. This covers break conditions.
- **Delivery:**
  - Holding register empty, or `I_data_ready` high in the same cycle → load `O_data` and assert `O_data_valid`.
  - Otherwise → drop the new byte, keep the old byte, set `O_overrun`.
- **Handshake:** `O_data_valid & I_data_ready` consumes the byte. `O_data_valid` falls next cycle unless a new byte loads in the same cycle, in which case it stays high with the new data.
- **Enable low:** the FSM is forced to IDLE on the next edge and the partial byte is discarded. The holding register and error flags are retained.
- **Error clear:** `I_clear_errors` clears both sticky flags. If an error sets in the same cycle, set wins.
- **Reset values:** `O_data = 0`, `O_data_valid = 0`, `O_framing_error = 0`, `O_overrun = 0`, `O_busy = 0`, FSM in IDLE.

## Timing
- Start-edge detection happens 2 cycles after the `I_swo` edge (synchronizer), plus 1 cycle when the filter is compiled in.
- Bit n (0..7) is sampled `half + (n + 1)(eff_div + 1)` cycles after start detection. The stop bit is sampled at `half + 9(eff_div + 1)`.
- `O_data_valid` rises one cycle after the stop-bit sample.
- Back-to-back frames with a full-length stop bit are received with no loss. IDLE rearms in the cycle after STOP.
- `O_busy` is registered, high from the cycle after start detection until IDLE is re-entered.

## Configuration
- `SWO_GLITCH_FILTER_EN`
  - Defined: `swo_s` is replaced by a 3-sample majority vote over consecutive synchronized samples. Adds 1 cycle of latency. Rejects single-cycle glitches.
  - Undefined: the raw synchronizer output is used, with no added latency.

## Test plan
- **Nominal byte:** `I_baud_div = 15`, send 0xA5 with a high stop bit, `I_data_ready = 1` → `O_data = 0xA5`, `O_data_valid` high 1 cycle, no error flags.
- **False start:** 6-cycle low pulse on idle line, `I_baud_div = 15` → FSM returns to IDLE, no valid, no errors.
  - With the filter compiled in, a 1-cycle pulse → `O_busy` never rises.
- **Framing error:** send 0x3C with the stop bit low, then hold low 40 cycles → `O_framing_error = 1`, no valid. A following 0x5A is received correctly after the line returns high.
- **Overrun:** `I_data_ready = 0`, send 0x11 then 0x22 → `O_data` stays 0x11, `O_overrun = 1`. Pulse `I_clear_errors` → flag clears, and 0x11 is still valid until ready.
- **Simultaneous ready and load:** hold 0x11 valid, assert `I_data_ready` exactly in the delivery cycle of 0x22 → `O_data` becomes 0x22, valid stays high, no overrun.
- **Reset/enable mid-frame:** assert `reset_n = 0` during bit 3 → all outputs are at reset values immediately. Drop `I_enable` mid-frame → FSM returns to IDLE, no byte. `I_baud_div = 1` behaves exactly like 3 (4 cycles/bit).
